// File: rtl/l2_req_arbiter_pkg.sv
// Shared cache-side definitions: request/response buses, arbiter states and requester ids.
// Pure declarations; no logic, no latency.
package cache_def;

  typedef struct packed {
    logic         valid;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } mem_req_type;

  typedef struct packed {
    logic         ready;
    logic [127:0] data;
  } mem_data_type;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_type;

  localparam logic ARB_ID_ICACHE = 1'b0;
  localparam logic ARB_ID_DCACHE = 1'b1;

endpackage

// File: rtl/l2_req_arbiter_if.sv
// Bundle of the two cache-side ports and the single L2-side port of the arbiter.
// slave = arbiter side, master = caches plus L2 controller side.
interface l2_req_arbiter_if;
  import cache_def::*;

  mem_req_type  icache_req_i;
  mem_req_type  dcache_req_i;
  mem_data_type icache_res_o;
  mem_data_type dcache_res_o;
  mem_req_type  l2_req_o;
  mem_data_type l2_res_i;

  modport slave (
    input  icache_req_i, dcache_req_i, l2_res_i,
    output icache_res_o, dcache_res_o, l2_req_o
  );

  modport master (
    output icache_req_i, dcache_req_i, l2_res_i,
    input  icache_res_o, dcache_res_o, l2_req_o
  );

endinterface

// File: rtl/adder_32bit.sv
// 32-bit ripple adder with carry in/out, shared by the counter datapaths.
// Combinational; no backpressure.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/l2_req_arbiter_rr.sv
// Two-way round-robin: holds the last-served id and picks the winner combinationally.
// Winner is same-cycle from req; pointer moves only when update is pulsed.
module l2_arb_rr
  import cache_def::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner,
  output logic       winner
);

  logic last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= ARB_ID_ICACHE;
    end else if (update) begin
      last_q <= owner;
    end
  end

  // A tie goes to whoever was not served last; otherwise the sole requester wins.
  always_comb begin
    winner = ARB_ID_ICACHE;
    if (req == 2'b11) begin
      winner = ~last_q;
    end else if (req[ARB_ID_DCACHE]) begin
      winner = ARB_ID_DCACHE;
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Merges I-/D-cache miss traffic onto one L2 port; one transaction at a time, L2 latency + 2 turnaround.
// Requesters are held off (inputs ignored) while busy; ARB_PERF_CNT_EN adds saturating grant counters.
module l2_req_arbiter
  import cache_def::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  l2_req_arbiter_if.slave bus,
  output logic            busy_o,
  output logic            gnt_id_o,
  output logic [31:0]     icache_gnt_cnt_o,
  output logic [31:0]     dcache_gnt_cnt_o
);

  arb_state_type state_q, state_d;
  mem_req_type   req_q, req_d;
  logic          gnt_id_q, gnt_id_d;
  logic [1:0]    req_vld;
  logic          winner;
  logic          grant;
  logic          rr_update;

  assign req_vld = {bus.dcache_req_i.valid, bus.icache_req_i.valid};

  l2_arb_rr u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req_vld),
    .update (rr_update),
    .owner  (gnt_id_q),
    .winner (winner)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      req_q    <= '0;
      gnt_id_q <= ARB_ID_ICACHE;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    gnt_id_d         = gnt_id_q;
    grant            = 1'b0;
    rr_update        = 1'b0;
    bus.icache_res_o = '0;
    bus.dcache_res_o = '0;
    bus.l2_req_o       = req_q;
    bus.l2_req_o.valid = req_q.valid & (state_q == ARB_BUSY);

    case (state_q)
      ARB_IDLE: begin
        if (|req_vld) begin
          grant    = 1'b1;
          gnt_id_d = winner;
          req_d    = (winner == ARB_ID_DCACHE) ? bus.dcache_req_i : bus.icache_req_i;
          state_d  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (bus.l2_res_i.ready) begin
          if (gnt_id_q == ARB_ID_DCACHE) begin
            bus.dcache_res_o = '{ready: 1'b1, data: bus.l2_res_i.data};
          end else begin
            bus.icache_res_o = '{ready: 1'b1, data: bus.l2_res_i.data};
          end
          rr_update = 1'b1;
          state_d   = ARB_DONE;
        end
      end
      // One dead cycle so the owner can drop its stale valid and L2 can go idle.
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign busy_o   = (state_q != ARB_IDLE);
  assign gnt_id_o = gnt_id_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] icnt_q, dcnt_q, icnt_inc, dcnt_inc;
  logic        icnt_co, dcnt_co;

  adder_32bit u_icnt_add (
    .a    (icnt_q),
    .b    (32'd0),
    .cin  (1'b1),
    .sum  (icnt_inc),
    .cout (icnt_co)
  );

  adder_32bit u_dcnt_add (
    .a    (dcnt_q),
    .b    (32'd0),
    .cin  (1'b1),
    .sum  (dcnt_inc),
    .cout (dcnt_co)
  );

  // Carry out of +1 means the counter is already all-ones: hold it there.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      icnt_q <= '0;
      dcnt_q <= '0;
    end else if (grant) begin
      if (gnt_id_d == ARB_ID_ICACHE && !icnt_co) begin
        icnt_q <= icnt_inc;
      end
      if (gnt_id_d == ARB_ID_DCACHE && !dcnt_co) begin
        dcnt_q <= dcnt_inc;
      end
    end
  end

  assign icache_gnt_cnt_o = icnt_q;
  assign dcache_gnt_cnt_o = dcnt_q;
`else
  assign icache_gnt_cnt_o = '0;
  assign dcache_gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: directed scenarios then randomized traffic against a transaction-level model.
module tb_l2_req_arbiter;
  import cache_def::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        busy_o;
  logic        gnt_id_o;
  logic [31:0] icnt;
  logic [31:0] dcnt;

  l2_req_arbiter_if bus ();

  l2_req_arbiter dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .bus              (bus),
    .busy_o           (busy_o),
    .gnt_id_o         (gnt_id_o),
    .icache_gnt_cnt_o (icnt),
    .dcache_gnt_cnt_o (dcnt)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  bit          m_last;
  int unsigned m_icnt;
  int unsigned m_dcnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_counts(input string tag);
    logic [31:0] exp_i, exp_d;
`ifdef ARB_PERF_CNT_EN
    exp_i = m_icnt;
    exp_d = m_dcnt;
`else
    exp_i = 32'd0;
    exp_d = 32'd0;
`endif
    chk({tag, "_icnt"}, icnt, exp_i);
    chk({tag, "_dcnt"}, dcnt, exp_d);
  endtask

  // One full transaction starting from an idle arbiter; lat = BUSY cycle in which L2 answers.
  task automatic txn(input bit iv, input bit dv, input logic [31:0] ia, input logic [31:0] da,
                     input bit drw, input int lat, input logic [127:0] rdat, input bit hold);
    bit          win;
    mem_req_type ireq, dreq, exp;
    ireq = '{valid: iv, rw: 1'b0, addr: ia, data: rnd128()};
    dreq = '{valid: dv, rw: drw, addr: da, data: rnd128()};
    win  = (iv && dv) ? ~m_last : dv;
    exp  = win ? dreq : ireq;

    @(negedge clk_i);
    bus.icache_req_i = ireq;
    bus.dcache_req_i = dreq;
    bus.l2_res_i     = '{ready: 1'b0, data: rnd128()};
    #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_l2_vld", bus.l2_req_o.valid, 0);

    @(posedge clk_i); #1;
    if (win) m_dcnt++; else m_icnt++;
    chk("gnt_id", gnt_id_o, win);
    chk("grant_busy", busy_o, 1);

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk_i);
      bus.icache_req_i = '{valid: 1'($urandom), rw: 1'b0, addr: $urandom, data: rnd128()};
      bus.dcache_req_i = '{valid: 1'($urandom), rw: 1'($urandom), addr: $urandom, data: rnd128()};
      bus.l2_res_i     = '{ready: (c == lat), data: (c == lat) ? rdat : rnd128()};
      #1;
      chk("l2_vld", bus.l2_req_o.valid, 1);
      chk("l2_addr", bus.l2_req_o.addr, exp.addr);
      chk("l2_rw", bus.l2_req_o.rw, exp.rw);
      chk("l2_data", bus.l2_req_o.data, exp.data);
      chk("i_rdy", bus.icache_res_o.ready, (c == lat) && !win);
      chk("i_dat", bus.icache_res_o.data, ((c == lat) && !win) ? rdat : 128'd0);
      chk("d_rdy", bus.dcache_res_o.ready, (c == lat) && win);
      chk("d_dat", bus.dcache_res_o.data, ((c == lat) && win) ? rdat : 128'd0);
      @(posedge clk_i); #1;
    end
    m_last = win;

    chk("done_busy", busy_o, 1);
    chk("done_l2_vld", bus.l2_req_o.valid, 0);
    @(negedge clk_i);
    bus.icache_req_i.valid = win ? 1'($urandom) : hold;
    bus.dcache_req_i.valid = win ? hold : 1'($urandom);
    bus.l2_res_i = '{ready: 1'b1, data: rnd128()};
    #1;
    chk("done_i_rdy", bus.icache_res_o.ready, 0);
    chk("done_d_rdy", bus.dcache_res_o.ready, 0);
    @(posedge clk_i); #1;
    chk("no_grant_from_done", busy_o, 0);
    bus.icache_req_i.valid = 1'b0;
    bus.dcache_req_i.valid = 1'b0;
    bus.l2_res_i.ready     = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      bus.icache_req_i.valid = 1'b0;
      bus.dcache_req_i.valid = 1'b0;
      bus.l2_res_i = '{ready: 1'($urandom), data: rnd128()};
      #1;
      chk("gap_i_rdy", bus.icache_res_o.ready, 0);
      chk("gap_d_rdy", bus.dcache_res_o.ready, 0);
      @(posedge clk_i); #1;
      chk("gap_busy", busy_o, 0);
    end
  endtask

  initial begin
    rst_ni           = 1'b0;
    bus.icache_req_i = '0;
    bus.dcache_req_i = '0;
    bus.l2_res_i     = '0;
    m_last = 1'b0;
    m_icnt = 0;
    m_dcnt = 0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_gnt", gnt_id_o, 0);
    chk("rst_l2_vld", bus.l2_req_o.valid, 0);
    chk("rst_l2_addr", bus.l2_req_o.addr, 0);
    chk("rst_i_rdy", bus.icache_res_o.ready, 0);
    chk("rst_d_rdy", bus.dcache_res_o.ready, 0);
    chk_counts("rst");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // First tie after reset goes to the D-cache, the next tie to the I-cache.
    txn(1'b1, 1'b1, 32'h0000_3000, 32'h0000_4000, 1'b0, 2, rnd128(), 1'b0);
    txn(1'b1, 1'b1, 32'h0000_3000, 32'h0000_4000, 1'b0, 1, rnd128(), 1'b0);
    txn(1'b1, 1'b0, 32'h0000_1040, 32'h0, 1'b0, 4, 128'hA5, 1'b0);
    txn(1'b0, 1'b1, 32'h0, 32'h0000_2000, 1'b1, 2, rnd128(), 1'b1);
    idle_gap(2);

    // Reset in the middle of a D-cache transaction.
    @(negedge clk_i);
    bus.dcache_req_i = '{valid: 1'b1, rw: 1'b1, addr: 32'hDEAD_0000, data: rnd128()};
    @(posedge clk_i); #1;
    chk("rst_pre_busy", busy_o, 1);
    @(negedge clk_i);
    bus.l2_res_i = '{ready: 1'b1, data: rnd128()};
    rst_ni = 1'b0;
    #1;
    chk("midrst_l2_vld", bus.l2_req_o.valid, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_d_rdy", bus.dcache_res_o.ready, 0);
    chk("midrst_d_dat", bus.dcache_res_o.data, 0);
    chk("midrst_i_rdy", bus.icache_res_o.ready, 0);
    chk("midrst_l2_addr", bus.l2_req_o.addr, 0);
    @(negedge clk_i);
    bus.dcache_req_i = '0;
    bus.l2_res_i     = '0;
    rst_ni           = 1'b1;
    m_last = 1'b0;
    m_icnt = 0;
    m_dcnt = 0;
    @(posedge clk_i); #1;
    chk("postrst_busy", busy_o, 0);
    chk_counts("postrst");

    for (int t = 0; t < 5; t++) txn(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1 + (t % 3), rnd128(), 1'b0);
    for (int t = 0; t < 3; t++) txn(1'b0, 1'b1, $urandom, $urandom, 1'b1, 1 + t, rnd128(), 1'b0);
    chk_counts("cnt53");

    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(1, 3);
      txn(r[0], r[1], $urandom, $urandom, 1'($urandom), $urandom_range(1, 4), rnd128(), 1'($urandom));
      idle_gap($urandom_range(0, 2));
    end
    chk_counts("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/l2_req_arbiter.md
L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

Interface
REQ-001 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-002 rst_ni  input  1  reset, asynchronous and active-low.
REQ-003 icache_req_i  input  mem_req_type  I-cache miss request (valid, rw, addr, data); rw always 0.
REQ-004 dcache_req_i  input  mem_req_type  D-cache miss or write-back request.
REQ-005 icache_res_o  output  mem_data_type  response to the I-cache (ready, data).
REQ-006 dcache_res_o  output  mem_data_type  response to the D-cache (ready, data).
REQ-007 l2_req_o  output  mem_req_type  single request port into the L2 cache controller.
REQ-008 l2_res_i  input  mem_data_type  L2 cache controller response (ready, data).
REQ-009 busy_o  output  1  high whenever a transaction is outstanding or in recovery.
REQ-010 gnt_id_o  output  1  owner of the current transaction: 0 means I-cache, 1 means D-cache.
REQ-011 icache_gnt_cnt_o, dcache_gnt_cnt_o  output  32  grant counters.

Function
REQ-012 The FSM SHALL have three states: ARB_IDLE, ARB_BUSY and ARB_DONE.
REQ-013 In ARB_IDLE with at least one requester valid, the block SHALL grant, capture the winner's addr, data and rw into a register, set gnt_id, and move to ARB_BUSY on the next edge.
REQ-014 Arbitration SHALL be two-way round-robin.
- When both requesters are valid, the one not granted last SHALL win.
- The pointer SHALL reset to "I-cache last", so the D-cache wins the first tie.
REQ-015 l2_req_o SHALL be driven from the captured register.
- l2_req_o.valid SHALL be 1 only in ARB_BUSY.
- addr, data and rw SHALL stay stable for the whole ARB_BUSY period.
REQ-016 In ARB_BUSY, requester inputs SHALL be ignored; a newly asserted request waits.
REQ-017 In ARB_BUSY with l2_res_i.ready=1, the block SHALL do all of the following in the same cycle:
- drive the owner's res.ready=1 and res.data=l2_res_i.data combinationally;
- update the round-robin pointer to the owner;
- move to ARB_DONE.
REQ-018 The non-owner's res.ready SHALL always be 0. res.data SHALL be 0 whenever ready is 0.
REQ-019 ARB_DONE SHALL last exactly one cycle and then return to ARB_IDLE.
- No grant is issued in ARB_DONE, which lets the owner drop its stale valid.
- l2_req_o.valid SHALL be 0 in ARB_DONE, which lets the L2 controller return to its idle state.
REQ-020 l2_res_i.ready received outside ARB_BUSY SHALL be ignored.
REQ-021 busy_o SHALL be 1 in ARB_BUSY and ARB_DONE, and 0 in ARB_IDLE.
REQ-022 Minimum turnaround from grant to the next grant SHALL be L2 latency + 2 cycles.
REQ-023 A requester that drops valid before ready is granted nothing. If it was already granted, the transaction SHALL complete and its response pulse SHALL still be driven.

Reset
REQ-024 On rst_ni=0 the block SHALL immediately enter the following state:
- state = ARB_IDLE;
- captured request register = all zeros;
- gnt_id = 0;
- round-robin pointer = I-cache last;
- counters = 0.
REQ-025 During reset all outputs SHALL be 0, including l2_req_o.valid and both res.ready.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction without issuing any response pulse.

Configuration
REQ-027 Macro ARB_PERF_CNT_EN SHALL control the grant counters.
- When defined, each counter SHALL increment by 1 on every grant to its requester and saturate at 32'hFFFF_FFFF.
- When undefined, no counter registers SHALL exist and both counter outputs SHALL be tied to 0.

Structure
REQ-028 Package cache_def SHALL hold the shared definitions:
- arb_state_type (ARB_IDLE, ARB_BUSY, ARB_DONE);
- ARB_ID_ICACHE = 1'b0 and ARB_ID_DCACHE = 1'b1;
- the existing mem_req_type and mem_data_type.
REQ-029 The pointer and winner-select logic SHALL live in one sub-module, l2_arb_rr, with inputs req[1:0] and update, and output winner.
- Counter increments SHALL reuse adder_32bit.

Verification
REQ-030 Only icache valid, addr 32'h0000_1040; L2 ready after 3 BUSY cycles with data 128'hA5 -> l2_req_o.addr=32'h0000_1040 and rw=0; icache_res_o.ready pulses for 1 cycle with data 128'hA5; dcache_res_o.ready stays 0.
REQ-031 Both valid in the same cycle after reset -> D-cache granted first; I-cache granted immediately after ARB_DONE; gnt_id sequence 1, 0.
REQ-032 D-cache write rw=1, addr 32'h0000_2000; D-cache valid held one extra cycle after ready -> exactly one L2 transaction; no second grant.
REQ-033 I-cache asserts valid while the D-cache transaction is in ARB_BUSY -> l2_req_o fields stay unchanged; I-cache granted only after ARB_DONE.
REQ-034 rst_ni pulled low in ARB_BUSY -> l2_req_o.valid=0 in the same cycle; no response pulse; state ARB_IDLE after release.
REQ-035 With ARB_PERF_CNT_EN defined, 5 I-cache and 3 D-cache transactions -> icache_gnt_cnt_o=5 and dcache_gnt_cnt_o=3. With it undefined, both outputs read 0.
